exdata_spill_fifo: RTL and testbench

Downstream stage of the external-data pulse counter: watches the counter's `live` gate and, on each live falling edge, captures the final 32-bit count tagged with a spill index into a small first-word-fall-through FIFO. Readout logic drains the FIFO through a valid/ready handshake. The block decouples per-spill count production from readout latency and tracks spills lost to FIFO overflow.

---
 rtl/exdata_spill_fifo_if.sv | 26 ++
 rtl/exdata_spill_fifo.sv | 96 +++++++++
 tb/tb_exdata_spill_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/exdata_spill_fifo_if.sv
// Spill-FIFO bundle: clear, live gate and running count in; FWFT head, level and drop count out.
// The master side drives the inputs; the slave is the FIFO block itself.
interface exdata_spill_fifo_if #(
    parameter int CNT_W   = 32,
    parameter int SPILL_W = 16,
    parameter int DEPTH   = 8
);
    logic                       clr;
    logic [CNT_W-1:0]           cnt_in;
    logic                       live;
    logic                       rd_ready;
    logic                       out_valid;
    logic [SPILL_W+CNT_W-1:0]   out_data;
    logic [$clog2(DEPTH):0]     fifo_level;
    logic [15:0]                overflow_cnt;

    modport master (
        output clr, cnt_in, live, rd_ready,
        input  out_valid, out_data, fifo_level, overflow_cnt
    );

    modport slave (
        input  clr, cnt_in, live, rd_ready,
        output out_valid, out_data, fifo_level, overflow_cnt
    );
endinterface

// File: rtl/exdata_spill_fifo.sv
// Captures {spill_id, count} one cycle after each live falling edge into a FWFT FIFO.
// Entry visible 2 cycles after the fall is sampled; when full and not popping, the spill is dropped and counted.
module exdata_spill_fifo #(
    parameter int CNT_W   = 32,
    parameter int SPILL_W = 16,
    parameter int DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    exdata_spill_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [SPILL_W-1:0] spill_id;
        logic [CNT_W-1:0]   count;
    } entry_t;

    logic               r_live_d;
    logic               r_pending;
    logic [SPILL_W-1:0] r_spill_id;
    entry_t             r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LW-1:0]      r_level;
    logic [15:0]        r_ovf;

    logic   w_fall;
    logic   w_full;
    logic   w_empty;
    logic   w_pop;
    logic   w_push;
    logic   w_drop;
    entry_t w_entry;

    assign w_fall  = r_live_d & ~bus.live;
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & bus.rd_ready;
    // A full FIFO still accepts the capture when its head leaves on the same edge.
    assign w_push  = r_pending & (~w_full | w_pop);
    assign w_drop  = r_pending & ~w_push;
    assign w_entry = '{spill_id: r_spill_id, count: bus.cnt_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live_d   <= 1'b0;
            r_pending  <= 1'b0;
            r_spill_id <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.clr) begin
            // Taking live here swallows any fall that lands on the clear edge.
            r_live_d   <= bus.live;
            r_pending  <= 1'b0;
            r_spill_id <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= '0;
        end else begin
            r_live_d  <= bus.live;
            r_pending <= w_fall;
            if (r_pending) begin
                r_spill_id <= r_spill_id + SPILL_W'(1);
            end
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
            if (w_drop && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    assign bus.out_valid    = ~w_empty;
    assign bus.out_data     = r_mem[r_rd_ptr];
    assign bus.fifo_level   = r_level;
    assign bus.overflow_cnt = r_ovf;

endmodule

// File: tb/tb_exdata_spill_fifo.sv
// Randomized and directed bench for exdata_spill_fifo against a queue-based model of spill capture.
module tb_exdata_spill_fifo;
    localparam int CNT_W   = 32;
    localparam int SPILL_W = 16;
    localparam int DEPTH   = 8;
    localparam int DW      = SPILL_W + CNT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exdata_spill_fifo_if #(.CNT_W(CNT_W), .SPILL_W(SPILL_W), .DEPTH(DEPTH)) bus ();

    exdata_spill_fifo #(.CNT_W(CNT_W), .SPILL_W(SPILL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mq [$];
    logic [15:0]   m_sid;
    logic [15:0]   m_ovf;
    bit            m_pend;
    bit            m_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_sid  = '0;
        m_ovf  = '0;
        m_pend = 1'b0;
        m_prev = 1'b0;
    endtask

    // One clock edge of the spill rules: capture the cycle after a fall, tag every capture, drop when full.
    task automatic model_step();
        bit            pop;
        bit            accept;
        logic [DW-1:0] e;
        if (!rst_n) begin
            model_reset();
        end else if (bus.clr) begin
            mq.delete();
            m_sid  = '0;
            m_ovf  = '0;
            m_pend = 1'b0;
            m_prev = bus.live;
        end else begin
            pop    = (mq.size() != 0) && bus.rd_ready;
            accept = (mq.size() < DEPTH) || pop;
            e      = {m_sid, bus.cnt_in};
            if (pop) void'(mq.pop_front());
            if (m_pend) begin
                m_sid = m_sid + 16'd1;
                if (accept) mq.push_back(e);
                else if (m_ovf != 16'hFFFF) m_ovf = m_ovf + 16'd1;
            end
            m_pend = m_prev && !bus.live;
            m_prev = bus.live;
        end
    endtask

    task automatic compare_model();
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("fifo_level", 64'(bus.fifo_level), 64'(mq.size()));
        chk("overflow_cnt", 64'(bus.overflow_cnt), 64'(m_ovf));
        if (mq.size() != 0) chk("out_data", 64'(bus.out_data), 64'(mq[0]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic spill(input int nh, input bit rd_cap);
        for (int i = 0; i < nh; i++) begin
            bus.live = 1'b1; bus.cnt_in = $urandom(); cycle();
        end
        bus.live = 1'b0; bus.cnt_in = $urandom(); cycle();
        bus.cnt_in = $urandom();
        if (rd_cap) bus.rd_ready = 1'b1;
        cycle();
        bus.rd_ready = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1; bus.live = 1'b0; cycle();
        bus.clr = 1'b0;
    endtask

    int rdp;

    initial begin
        bus.clr = 1'b0; bus.live = 1'b0; bus.cnt_in = '0; bus.rd_ready = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_level", 64'(bus.fifo_level), 64'd0);
        chk("rst_ovf", 64'(bus.overflow_cnt), 64'd0);
        rst_n = 1'b1;

        // First spill: count stepping 0..9, fall, then capture sees 11.
        for (int i = 0; i < 10; i++) begin
            bus.live = 1'b1; bus.cnt_in = 32'(i); cycle();
        end
        bus.live = 1'b0; bus.cnt_in = 32'd10; cycle();
        chk("t1_valid_fall_edge", 64'(bus.out_valid), 64'd0);
        bus.cnt_in = 32'd11; cycle();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data", 64'(bus.out_data), {16'h0, 16'h0000, 32'd11});
        chk("t1_level", 64'(bus.fifo_level), 64'd1);

        // Five queued spills drained in order.
        do_clr();
        for (int s = 0; s < 5; s++) spill(3, 1'b0);
        chk("t2_level", 64'(bus.fifo_level), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_tag", 64'(bus.out_data[DW-1:CNT_W]), 64'(i));
            bus.rd_ready = 1'b1; cycle();
        end
        bus.rd_ready = 1'b0;
        chk("t2_empty", 64'(bus.out_valid), 64'd0);

        // Overflow: ten spills into eight slots.
        do_clr();
        for (int s = 0; s < 10; s++) spill(2, 1'b0);
        chk("t3_level", 64'(bus.fifo_level), 64'd8);
        chk("t3_ovf", 64'(bus.overflow_cnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            chk("t3_tag", 64'(bus.out_data[DW-1:CNT_W]), 64'(i));
            bus.rd_ready = 1'b1; cycle();
        end
        bus.rd_ready = 1'b0;
        spill(2, 1'b0);
        chk("t3_next_tag", 64'(bus.out_data[DW-1:CNT_W]), 64'd10);

        // Full FIFO, capture coincides with a pop.
        do_clr();
        for (int s = 0; s < 8; s++) spill(2, 1'b0);
        spill(2, 1'b1);
        chk("t4_level", 64'(bus.fifo_level), 64'd8);
        chk("t4_ovf", 64'(bus.overflow_cnt), 64'd0);
        chk("t4_head", 64'(bus.out_data[DW-1:CNT_W]), 64'd1);

        // Clear landing on a live fall.
        spill(2, 1'b0);
        spill(2, 1'b0);
        chk("t5_ovf_pre", 64'(bus.overflow_cnt), 64'd2);
        for (int i = 0; i < 3; i++) begin
            bus.live = 1'b1; cycle();
        end
        bus.live = 1'b0; bus.clr = 1'b1; cycle();
        bus.clr = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_level", 64'(bus.fifo_level), 64'd0);
        chk("t5_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_ovf", 64'(bus.overflow_cnt), 64'd0);
        spill(2, 1'b0);
        chk("t5_tag", 64'(bus.out_data[DW-1:CNT_W]), 64'd0);

        // Asynchronous reset mid-spill with entries queued.
        do_clr();
        for (int s = 0; s < 3; s++) spill(2, 1'b0);
        bus.live = 1'b1; cycle(); cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_data", 64'(bus.out_data), 64'd0);
        chk("t6_level", 64'(bus.fifo_level), 64'd0);
        chk("t6_ovf", 64'(bus.overflow_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        cycle(); cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("t6_no_capture", 64'(bus.fifo_level), 64'd0);
        bus.live = 1'b0; cycle(); cycle();
        chk("t6_level_after", 64'(bus.fifo_level), 64'd1);
        chk("t6_tag_after", 64'(bus.out_data[DW-1:CNT_W]), 64'd0);

        // Random traffic at several consumer duty cycles.
        for (int ph = 0; ph < 4; ph++) begin
            rdp = (ph == 0) ? 5 : (ph == 1) ? 30 : (ph == 2) ? 70 : 100;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) bus.live = ~bus.live;
                bus.cnt_in   = $urandom();
                bus.rd_ready = ($urandom_range(0, 99) < rdp);
                bus.clr      = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        bus.clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
